// File: rtl/core_ex_lsu.sv
// rtl/core_ex_lsu.sv - execute-stage load/store unit, single outstanding memory op
// Aligns store lanes/strobes, extends load data, returns one completion record per op.
module core_ex_lsu #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_load,
  input  logic                   i_store,
  input  logic                   i_size_b,
  input  logic                   i_size_h,
  input  logic                   i_size_w,
  input  logic                   i_lu,
  input  logic [XLEN-1:0]        i_addr,
  input  logic [XLEN-1:0]        i_wdata,
  input  logic [RFIDX_WIDTH-1:0] i_rd_idx,
  output logic                   o_mem_req_valid,
  input  logic                   i_mem_req_ready,
  output logic [XLEN-1:0]        o_mem_req_addr,
  output logic                   o_mem_req_wen,
  output logic [3:0]             o_mem_req_wstrb,
  output logic [XLEN-1:0]        o_mem_req_wdata,
  input  logic                   i_mem_rsp_valid,
  output logic                   o_mem_rsp_ready,
  input  logic [XLEN-1:0]        i_mem_rsp_rdata,
  input  logic                   i_mem_rsp_err,
  output logic                   o_wb_valid,
  input  logic                   i_wb_ready,
  output logic                   o_wb_rd_wen,
  output logic [RFIDX_WIDTH-1:0] o_wb_rd_idx,
  output logic [XLEN-1:0]        o_wb_rdata,
  output logic [1:0]             o_wb_err_code,
  output logic [XLEN-1:0]        o_wb_badaddr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [XLEN-1:0]        addr_q, wdata_q, rdata_q;
  logic [RFIDX_WIDTH-1:0] rd_idx_q;
  logic                   load_q, store_q, size_b_q, size_h_q, size_w_q, lu_q, rd_wen_q;
  logic [1:0]             err_q;

  logic            legal, misaligned, accept, rsp_fire;
  logic [XLEN-1:0] lane, load_ext;

  assign legal      = (i_load ^ i_store) &&
                      ({i_size_b, i_size_h, i_size_w} inside {3'b100, 3'b010, 3'b001});
  assign misaligned = (i_size_h & i_addr[0]) | (i_size_w & (|i_addr[1:0]));
  assign accept     = (state_q == IDLE) && i_valid;
  assign rsp_fire   = (state_q == WAIT) && i_mem_rsp_valid;

  assign lane = i_mem_rsp_rdata >> {addr_q[1:0], 3'b000};
  always_comb begin
    load_ext = lane;
    if (size_b_q)      load_ext = {{(XLEN-8){~lu_q & lane[7]}}, lane[7:0]};
    else if (size_h_q) load_ext = {{(XLEN-16){~lu_q & lane[15]}}, lane[15:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    o_ready         = 1'b0;
    o_mem_req_valid = 1'b0;
    o_mem_rsp_ready = 1'b0;
    o_wb_valid      = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = (!legal || misaligned) ? DONE : REQ;
      end
      REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        o_mem_rsp_ready = 1'b1;
        if (i_mem_rsp_valid) state_d = DONE;
      end
      DONE: begin
        o_wb_valid = 1'b1;
        if (i_wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Op context is latched on accept; the result fields are rewritten once on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rd_idx_q <= '0;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      size_b_q <= 1'b0;
      size_h_q <= 1'b0;
      size_w_q <= 1'b0;
      lu_q     <= 1'b0;
      rd_wen_q <= 1'b0;
      err_q    <= 2'b00;
    end else begin
      if (accept) begin
        addr_q   <= i_addr;
        wdata_q  <= i_wdata;
        rd_idx_q <= i_rd_idx;
        load_q   <= i_load;
        store_q  <= i_store;
        size_b_q <= i_size_b;
        size_h_q <= i_size_h;
        size_w_q <= i_size_w;
        lu_q     <= i_lu;
        rdata_q  <= '0;
        rd_wen_q <= 1'b0;
        err_q    <= !legal ? 2'b11 : (misaligned ? 2'b01 : 2'b00);
      end
      if (rsp_fire) begin
        if (i_mem_rsp_err) begin
          err_q   <= 2'b10;
          rdata_q <= '0;
        end else if (load_q) begin
          rdata_q  <= load_ext;
          rd_wen_q <= (rd_idx_q != '0);
        end
      end
    end
  end

  assign o_mem_req_addr = {addr_q[XLEN-1:2], 2'b00};
  assign o_mem_req_wen  = store_q;

  always_comb begin
    o_mem_req_wstrb = 4'b0000;
    o_mem_req_wdata = '0;
    if (store_q) begin
      if (size_b_q) begin
        o_mem_req_wstrb = 4'b0001 << addr_q[1:0];
        o_mem_req_wdata = {4{wdata_q[7:0]}};
      end else if (size_h_q) begin
        o_mem_req_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        o_mem_req_wdata = {2{wdata_q[15:0]}};
      end else if (size_w_q) begin
        o_mem_req_wstrb = 4'b1111;
        o_mem_req_wdata = wdata_q;
      end
    end
  end

  assign o_wb_rd_wen   = rd_wen_q;
  assign o_wb_rd_idx   = rd_idx_q;
  assign o_wb_rdata    = rdata_q;
  assign o_wb_err_code = err_q;
  assign o_wb_badaddr  = addr_q;

endmodule

// File: tb/tb_core_ex_lsu.sv
// tb/tb_core_ex_lsu.sv - directed self-checking bench for core_ex_lsu
module tb_core_ex_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 0, i_load = 0, i_store = 0, i_size_b = 0, i_size_h = 0, i_size_w = 0, i_lu = 0;
  logic [31:0] i_addr = '0, i_wdata = '0;
  logic [4:0]  i_rd_idx = '0;
  logic        o_ready, o_mem_req_valid, o_mem_req_wen, o_mem_rsp_ready, o_wb_valid, o_wb_rd_wen;
  logic        i_mem_req_ready = 0, i_mem_rsp_valid = 0, i_mem_rsp_err = 0, i_wb_ready = 0;
  logic [31:0] o_mem_req_addr, o_mem_req_wdata, o_wb_rdata, o_wb_badaddr;
  logic [31:0] i_mem_rsp_rdata = '0;
  logic [3:0]  o_mem_req_wstrb;
  logic [4:0]  o_wb_rd_idx;
  logic [1:0]  o_wb_err_code;

  core_ex_lsu #(.XLEN(32), .RFIDX_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_load(i_load), .i_store(i_store), .i_size_b(i_size_b), .i_size_h(i_size_h),
    .i_size_w(i_size_w), .i_lu(i_lu), .i_addr(i_addr), .i_wdata(i_wdata), .i_rd_idx(i_rd_idx),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_addr(o_mem_req_addr), .o_mem_req_wen(o_mem_req_wen),
    .o_mem_req_wstrb(o_mem_req_wstrb), .o_mem_req_wdata(o_mem_req_wdata),
    .i_mem_rsp_valid(i_mem_rsp_valid), .o_mem_rsp_ready(o_mem_rsp_ready),
    .i_mem_rsp_rdata(i_mem_rsp_rdata), .i_mem_rsp_err(i_mem_rsp_err),
    .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rd_wen(o_wb_rd_wen),
    .o_wb_rd_idx(o_wb_rd_idx), .o_wb_rdata(o_wb_rdata), .o_wb_err_code(o_wb_err_code),
    .o_wb_badaddr(o_wb_badaddr)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Memory responder: decides handshakes at the falling edge for the next rising edge.
  int          req_stall = 0, rsp_stall = 0, req_wait = 0, rsp_wait = 0;
  int          req_hs = 0, rsp_hs = 0, req_seen = 0, req_unstable = 0;
  logic        rsp_pending = 0, chk_req = 0, mem_err = 0;
  logic [31:0] mem_rdata = '0, cap_addr = '0, cap_wdata = '0, exp_addr = '0, exp_wdata = '0;
  logic [3:0]  cap_wstrb = '0, exp_wstrb = '0;
  logic        cap_wen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      i_mem_req_ready = 0; i_mem_rsp_valid = 0; rsp_pending = 0; req_wait = 0; rsp_wait = 0;
    end else begin
      if (rsp_pending) begin
        if (rsp_wait < rsp_stall) begin
          i_mem_rsp_valid = 0; rsp_wait++;
        end else begin
          i_mem_rsp_valid = 1; i_mem_rsp_rdata = mem_rdata; i_mem_rsp_err = mem_err;
          if (o_mem_rsp_ready) begin rsp_hs++; rsp_pending = 0; end
        end
      end else begin
        i_mem_rsp_valid = 0; i_mem_rsp_err = 0;
      end
      if (o_mem_req_valid) begin
        req_seen++;
        if (chk_req && (o_mem_req_addr !== exp_addr || o_mem_req_wdata !== exp_wdata ||
                        o_mem_req_wstrb !== exp_wstrb)) req_unstable++;
        if (req_wait < req_stall) begin
          i_mem_req_ready = 0; req_wait++;
        end else begin
          i_mem_req_ready = 1; req_hs++; req_wait = 0; rsp_pending = 1; rsp_wait = 0;
          cap_addr = o_mem_req_addr; cap_wdata = o_mem_req_wdata;
          cap_wstrb = o_mem_req_wstrb; cap_wen = o_mem_req_wen;
        end
      end else begin
        i_mem_req_ready = 0;
      end
    end
  end

  // Offers one op at a falling edge; returns once the completion record is visible.
  task automatic do_op(input logic ld, st, sb, sh, sw, lu, input logic [31:0] addr, wd,
                       input logic [4:0] rd, output int lat, output int busy_ready);
    i_valid = 1; i_load = ld; i_store = st; i_size_b = sb; i_size_h = sh; i_size_w = sw;
    i_lu = lu; i_addr = addr; i_wdata = wd; i_rd_idx = rd;
    @(negedge clk);
    i_valid = 0; lat = 1; busy_ready = 0;
    while (!o_wb_valid && lat < 60) begin
      if (o_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_wb();
    i_wb_ready = 1;
    @(negedge clk);
    i_wb_ready = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", o_ready); end
    checks++; if (o_mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", o_mem_req_valid); end
    checks++; if (o_wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b expected 0", o_wb_valid); end
    checks++; if (o_mem_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_rsp_ready: got %b expected 0", o_mem_rsp_ready); end
    checks++; if ({o_wb_rdata, o_wb_err_code, o_wb_badaddr, o_mem_req_wstrb} !== '0) begin errors++; $display("FAIL rst_regs: got nonzero record/strobes expected 0"); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_loads();
    int lat, br;
    mem_rdata = 32'h80FF_1234;
    do_op(1, 0, 1, 0, 0, 0, 32'h1003, 32'h0, 5'd5, lat, br);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d expected 3", lat); end
    checks++; if (o_wb_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", o_wb_rdata); end
    checks++; if (o_wb_rd_wen !== 1'b1 || o_wb_rd_idx !== 5'd5) begin errors++; $display("FAIL lb_rd: got wen=%b idx=%0d expected wen=1 idx=5", o_wb_rd_wen, o_wb_rd_idx); end
    checks++; if (o_wb_err_code !== 2'b00) begin errors++; $display("FAIL lb_code: got %b expected 00", o_wb_err_code); end
    checks++; if (cap_addr !== 32'h1000 || cap_wstrb !== 4'b0000 || cap_wen !== 1'b0) begin errors++; $display("FAIL lb_req: got addr=%h wstrb=%b wen=%b expected 00001000 0000 0", cap_addr, cap_wstrb, cap_wen); end
    checks++; if (br !== 0) begin errors++; $display("FAIL lb_busy_ready: got %0d expected 0", br); end
    finish_wb();
    checks++; if (o_ready !== 1'b1 || o_wb_valid !== 1'b0) begin errors++; $display("FAIL lb_release: got ready=%b wb_valid=%b expected 1 0", o_ready, o_wb_valid); end

    mem_rdata = 32'h8001_0000;
    do_op(1, 0, 0, 1, 0, 1, 32'h2002, 32'h0, 5'd7, lat, br);
    checks++; if (o_wb_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_rdata: got %h expected 00008001", o_wb_rdata); end
    checks++; if (cap_addr !== 32'h2000) begin errors++; $display("FAIL lhu_addr: got %h expected 00002000", cap_addr); end
    finish_wb();
    do_op(1, 0, 0, 1, 0, 0, 32'h2002, 32'h0, 5'd7, lat, br);
    checks++; if (o_wb_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_rdata: got %h expected ffff8001", o_wb_rdata); end
    finish_wb();
    mem_rdata = 32'hF00D_CAFE;
    do_op(1, 0, 0, 0, 1, 1, 32'h2004, 32'h0, 5'd8, lat, br);
    checks++; if (o_wb_rdata !== 32'hF00D_CAFE) begin errors++; $display("FAIL lw_rdata: got %h expected f00dcafe", o_wb_rdata); end
    finish_wb();
  endtask

  task automatic test_stores();
    int lat, br;
    mem_rdata = 32'hFFFF_FFFF;
    do_op(0, 1, 1, 0, 0, 0, 32'h10, 32'h0000_00AB, 5'd4, lat, br);
    checks++; if (cap_wstrb !== 4'b0001 || cap_wdata !== 32'hABAB_ABAB || cap_wen !== 1'b1) begin errors++; $display("FAIL sb_req: got wstrb=%b wdata=%h wen=%b expected 0001 abababab 1", cap_wstrb, cap_wdata, cap_wen); end
    checks++; if (o_wb_rd_wen !== 1'b0 || o_wb_rdata !== 32'h0 || o_wb_err_code !== 2'b00) begin errors++; $display("FAIL sb_wb: got wen=%b rdata=%h code=%b expected 0 00000000 00", o_wb_rd_wen, o_wb_rdata, o_wb_err_code); end
    finish_wb();
    do_op(0, 1, 0, 1, 0, 0, 32'h12, 32'h0000_1234, 5'd4, lat, br);
    checks++; if (cap_wstrb !== 4'b1100 || cap_wdata !== 32'h1234_1234 || cap_addr !== 32'h10) begin errors++; $display("FAIL sh_req: got wstrb=%b wdata=%h addr=%h expected 1100 12341234 00000010", cap_wstrb, cap_wdata, cap_addr); end
    checks++; if (o_wb_rd_wen !== 1'b0) begin errors++; $display("FAIL sh_rd_wen: got %b expected 0", o_wb_rd_wen); end
    finish_wb();
    do_op(0, 1, 1, 0, 0, 0, 32'h13, 32'h0000_005A, 5'd0, lat, br);
    checks++; if (cap_wstrb !== 4'b1000 || cap_wdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL sb3_req: got wstrb=%b wdata=%h expected 1000 5a5a5a5a", cap_wstrb, cap_wdata); end
    finish_wb();
    do_op(0, 1, 0, 0, 1, 0, 32'h8, 32'hCAFE_F00D, 5'd0, lat, br);
    checks++; if (cap_wstrb !== 4'b1111 || cap_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL sw_req: got wstrb=%b wdata=%h expected 1111 cafef00d", cap_wstrb, cap_wdata); end
    finish_wb();
  endtask

  task automatic test_errors();
    int lat, br, seen0;
    seen0 = req_seen;
    do_op(1, 0, 0, 0, 1, 0, 32'h105, 32'h0, 5'd6, lat, br);
    checks++; if (o_wb_err_code !== 2'b01 || o_wb_badaddr !== 32'h105) begin errors++; $display("FAIL lw_mis: got code=%b badaddr=%h expected 01 00000105", o_wb_err_code, o_wb_badaddr); end
    checks++; if (lat !== 1 || o_wb_rd_wen !== 1'b0) begin errors++; $display("FAIL lw_mis_lat: got lat=%0d wen=%b expected 1 0", lat, o_wb_rd_wen); end
    finish_wb();
    do_op(1, 0, 0, 1, 0, 0, 32'h201, 32'h0, 5'd6, lat, br);
    checks++; if (o_wb_err_code !== 2'b01) begin errors++; $display("FAIL lh_mis: got code=%b expected 01", o_wb_err_code); end
    finish_wb();
    checks++; if (req_seen !== seen0) begin errors++; $display("FAIL mis_no_req: got %0d request cycles expected 0", req_seen - seen0); end
    do_op(1, 1, 0, 0, 1, 0, 32'h0, 32'h0, 5'd6, lat, br);
    checks++; if (o_wb_err_code !== 2'b11 || o_wb_rd_wen !== 1'b0) begin errors++; $display("FAIL ld_st_illegal: got code=%b wen=%b expected 11 0", o_wb_err_code, o_wb_rd_wen); end
    finish_wb();
    do_op(1, 0, 1, 1, 0, 0, 32'h0, 32'h0, 5'd6, lat, br);
    checks++; if (o_wb_err_code !== 2'b11) begin errors++; $display("FAIL two_sizes_illegal: got code=%b expected 11", o_wb_err_code); end
    finish_wb();
    checks++; if (req_seen !== seen0) begin errors++; $display("FAIL illegal_no_req: got %0d request cycles expected 0", req_seen - seen0); end
    mem_rdata = 32'h7F00_0000;
    do_op(1, 0, 1, 0, 0, 0, 32'h3, 32'h0, 5'd0, lat, br);
    checks++; if (o_wb_rd_wen !== 1'b0 || o_wb_rdata !== 32'h7F || o_wb_err_code !== 2'b00) begin errors++; $display("FAIL lb_x0: got wen=%b rdata=%h code=%b expected 0 0000007f 00", o_wb_rd_wen, o_wb_rdata, o_wb_err_code); end
    finish_wb();
  endtask

  task automatic test_backpressure();
    int lat, br, rq0, rs0;
    req_stall = 3; rsp_stall = 2;
    exp_addr = 32'h40; exp_wdata = 32'h1122_3344; exp_wstrb = 4'b1111; chk_req = 1;
    rq0 = req_hs; rs0 = rsp_hs; req_unstable = 0;
    do_op(0, 1, 0, 0, 1, 0, 32'h40, 32'h1122_3344, 5'd2, lat, br);
    chk_req = 0;
    checks++; if (lat !== 8) begin errors++; $display("FAIL bp_latency: got %0d expected 8", lat); end
    checks++; if (req_unstable !== 0) begin errors++; $display("FAIL bp_req_stable: got %0d unstable cycles expected 0", req_unstable); end
    checks++; if (req_hs - rq0 !== 1 || rsp_hs - rs0 !== 1) begin errors++; $display("FAIL bp_handshakes: got req=%0d rsp=%0d expected 1 1", req_hs - rq0, rsp_hs - rs0); end
    checks++; if (br !== 0) begin errors++; $display("FAIL bp_ready_low: got %0d ready cycles expected 0", br); end
    repeat (2) @(negedge clk);
    checks++; if (o_wb_valid !== 1'b1 || o_ready !== 1'b0 || o_wb_err_code !== 2'b00 || o_wb_rd_idx !== 5'd2) begin errors++; $display("FAIL bp_wb_hold: got valid=%b ready=%b code=%b idx=%0d expected 1 0 00 2", o_wb_valid, o_ready, o_wb_err_code, o_wb_rd_idx); end
    finish_wb();
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", o_ready); end
    mem_err = 1; mem_rdata = 32'hDEAD_BEEF; req_stall = 0; rsp_stall = 1;
    do_op(1, 0, 0, 0, 1, 0, 32'h44, 32'h0, 5'd9, lat, br);
    checks++; if (o_wb_err_code !== 2'b10 || o_wb_rdata !== 32'h0 || o_wb_rd_wen !== 1'b0 || o_wb_badaddr !== 32'h44) begin errors++; $display("FAIL bus_err: got code=%b rdata=%h wen=%b badaddr=%h expected 10 00000000 0 00000044", o_wb_err_code, o_wb_rdata, o_wb_rd_wen, o_wb_badaddr); end
    finish_wb();
    mem_err = 0; rsp_stall = 0;
  endtask

  task automatic test_reset_mid();
    int lat, br;
    rsp_stall = 5; mem_rdata = 32'h1234_5678;
    i_valid = 1; i_load = 1; i_store = 0; i_size_b = 0; i_size_h = 0; i_size_w = 1; i_lu = 0;
    i_addr = 32'h0; i_rd_idx = 5'd3;
    @(negedge clk);
    i_valid = 0;
    @(negedge clk);
    checks++; if (o_mem_rsp_ready !== 1'b1) begin errors++; $display("FAIL mid_in_wait: got rsp_ready=%b expected 1", o_mem_rsp_ready); end
    #2 rst_n = 0;
    #1;
    checks++; if (o_ready !== 1'b1 || o_wb_valid !== 1'b0 || o_mem_rsp_ready !== 1'b0) begin errors++; $display("FAIL mid_async: got ready=%b wb_valid=%b rsp_ready=%b expected 1 0 0", o_ready, o_wb_valid, o_mem_rsp_ready); end
    rsp_pending = 0; i_mem_rsp_valid = 0; i_mem_req_ready = 0;
    @(negedge clk);
    #2 rst_n = 1;
    rsp_stall = 0;
    @(negedge clk);
    checks++; if (o_ready !== 1'b1 || o_wb_valid !== 1'b0) begin errors++; $display("FAIL mid_after: got ready=%b wb_valid=%b expected 1 0", o_ready, o_wb_valid); end
    do_op(1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 5'd3, lat, br);
    checks++; if (lat !== 3 || o_wb_rdata !== 32'h1234_5678 || o_wb_rd_wen !== 1'b1 || o_wb_err_code !== 2'b00) begin errors++; $display("FAIL mid_next_lw: got lat=%0d rdata=%h wen=%b code=%b expected 3 12345678 1 00", lat, o_wb_rdata, o_wb_rd_wen, o_wb_err_code); end
    finish_wb();
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_ex_lsu.md
Name: core_ex_lsu

Overview:
- Execute-stage load/store unit: the consuming end of the decoder's LSU instruction bus (load/store flags, B/H/W size, LU unsigned flag).
- Takes one decoded memory op plus the ALU-computed effective address and the rs2 store data.
- Drives a single-outstanding valid/ready request/response memory port, aligns store data and byte strobes, extracts and extends load data.
- Returns one writeback/completion record per op, carrying an error code for misaligned, bus-error or illegal ops.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- RFIDX_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  op offered.
- o_ready  out  1  LSU idle, can accept an op.
- i_load  in  1  load op.
- i_store  in  1  store op.
- i_size_b  in  1  byte size.
- i_size_h  in  1  halfword size.
- i_size_w  in  1  word size.
- i_lu  in  1  zero-extend load.
- i_addr  in  XLEN  effective address.
- i_wdata  in  XLEN  store data (rs2).
- i_rd_idx  in  RFIDX_WIDTH  load destination register.
- o_mem_req_valid  out  1  memory request valid.
- i_mem_req_ready  in  1  memory accepts request.
- o_mem_req_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- o_mem_req_wen  out  1  1 = write.
- o_mem_req_wstrb  out  4  byte strobes.
- o_mem_req_wdata  out  XLEN  lane-replicated store data.
- i_mem_rsp_valid  in  1  response valid.
- o_mem_rsp_ready  out  1  LSU accepts response.
- i_mem_rsp_rdata  in  XLEN  read word.
- i_mem_rsp_err  in  1  bus error.
- o_wb_valid  out  1  completion record valid.
- i_wb_ready  in  1  writeback consumes record.
- o_wb_rd_wen  out  1  write register file.
- o_wb_rd_idx  out  RFIDX_WIDTH  destination index.
- o_wb_rdata  out  XLEN  extended load result (0 for stores/errors).
- o_wb_err_code  out  2  00 ok, 01 misaligned, 10 bus error, 11 illegal op.
- o_wb_badaddr  out  XLEN  latched i_addr (valid when err_code != 00).

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. Reset → IDLE; all outputs and registers are 0 except o_ready=1.
- IDLE: o_ready=1. i_valid latches addr, wdata, rd_idx, flags and size.
  - Legal op = exactly one of load/store and exactly one of size_b/h/w.
  - Illegal op → DONE, code 11.
  - Misaligned (H with addr[0]=1, or W with addr[1:0]!=0) → DONE, code 01. No memory request is issued.
  - Otherwise → REQ.
- REQ: o_mem_req_valid=1, fields stable until handshake. On i_mem_req_ready → WAIT.
- WAIT: o_mem_rsp_ready=1. On i_mem_rsp_valid, capture rdata and err → DONE. A response is never accepted in REQ.
- DONE: o_wb_valid=1, record stable until i_wb_ready → IDLE. No new op is accepted in the same cycle; o_ready rises the cycle after.
- Store strobes:
  - B: 4'b0001<<addr[1:0].
  - H: addr[1] ? 4'b1100 : 4'b0011.
  - W: 4'b1111.
- Store data: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata. Loads drive wen=0 and wstrb=0.
- Load extract: lane = rdata >> {addr[1:0],3'b000}. Sign-extend bit 7 (B) or bit 15 (H) unless i_lu; W ignores i_lu.
- o_wb_rd_wen = load & code==00 & rd_idx!=0. Stores always report rd_wen=0.
- i_mem_rsp_err=1 → code 10, rdata 0, rd_wen 0.
- Minimum latency (zero-wait memory): accept cycle 0, request cycle 1, response cycle 2, wb_valid cycle 3.
- Single outstanding transaction; the memory side's reset is applied together with the LSU's.
- Reset asserted mid-operation → immediately IDLE; valids drop asynchronously and the in-flight op is discarded.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_1234 → wstrb 0, req addr 0x1000, o_wb_rdata 0xFFFF_FF80, rd_wen=1, code 00, wb_valid at cycle 3.
- LHU, addr 0x2002, rdata 0x8001_0000 → 0x0000_8001; LH same → 0xFFFF_8001.
- SB, addr 0x10, wdata 0x0000_00AB → wstrb 0001, wdata 0xABAB_ABAB; SH, addr 0x12, wdata 0x1234 → wstrb 1100, wdata 0x1234_1234; wb rd_wen=0.
- LW, addr 0x105 → no mem_req_valid ever, code 01, badaddr 0x105; i_load=i_store=1 → code 11.
- Backpressure: i_mem_req_ready low 3 cycles, rsp delayed 2 cycles, i_wb_ready low 2 cycles → fields stable while waiting, exactly one handshake each, o_ready low throughout; bus error response → code 10, rd_wen=0.
- Reset pulse while in WAIT → next cycle o_ready=1, no wb_valid; following LW 0x0 completes normally.
